dram_cmd_issuer: RTL and testbench

- Sits directly downstream of the path address generator: takes its DDR3 command stream (Cmd/Addr with valid/ready) and drives the DDR3 controller's native command and write-data ports.
- Buffers commands in a small FIFO and pairs each write command with its write-data beats from the bucket datapath.
- Throttles reads so that the number of outstanding read bursts stays within what the read-return buffer can absorb.

---
 rtl/dram_cmd_issuer_pkg.sv | 26 ++
 rtl/dram_cmd_issuer_cmd_fifo.sv | 52 +++++
 rtl/dram_cmd_issuer.sv | 157 +++++++++++++++
 tb/tb_dram_cmd_issuer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_cmd_issuer_pkg.sv
// Shared constants for the DDR3 command issuer: widths, command encodings,
// FSM state encoding and a constant-safe log2 helper.
package dram_cmd_issuer_pkg;

    localparam int DDRCWidth = 3;
    localparam int DDRAWidth = 28;
    localparam int DDRDWidth = 512;

    // Native-interface command encodings shared with the address generator.
    localparam logic [2:0] DDR3CMD_Write = 3'b000;
    localparam logic [2:0] DDR3CMD_Read  = 3'b001;

    typedef enum logic [1:0] {
        ST_Idle  = 2'd0,
        ST_WData = 2'd1,
        ST_Cmd   = 2'd2
    } state_t;

    function automatic int log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/dram_cmd_issuer_cmd_fifo.sv
// Synchronous FIFO holding {command, address} entries; depth must be a
// power of two so the pointers wrap naturally.
module cmd_fifo #(
    parameter int Width = 31,
    parameter int Depth = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     PushValid,
    input  logic [Width-1:0]         PushData,
    input  logic                     PopEnable,
    output logic [Width-1:0]         HeadData,
    output logic                     Full,
    output logic                     Empty,
    output logic [$clog2(Depth):0]   Count
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count;
    logic             push;
    logic             pop;

    // A push is dropped when full and a pop when empty, so the count can
    // never wrap.
    assign push     = PushValid && !Full;
    assign pop      = PopEnable && !Empty;
    assign Full     = (count == CntW'(Depth));
    assign Empty    = (count == '0);
    assign Count    = count;
    assign HeadData = mem[rd_ptr];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
            count <= count + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge Clock) begin
        if (push) mem[wr_ptr] <= PushData;
    end

endmodule

// File: rtl/dram_cmd_issuer.sv
// Issues buffered DDR3 commands to the controller, sending each write's data
// beats ahead of its command and capping outstanding read beats.
module dram_cmd_issuer #(
    parameter int DDRCWidth    = dram_cmd_issuer_pkg::DDRCWidth,
    parameter int DDRAWidth    = dram_cmd_issuer_pkg::DDRAWidth,
    parameter int DDRDWidth    = dram_cmd_issuer_pkg::DDRDWidth,
    parameter int WBeatsPerCmd = 1,
    parameter int CmdFIFODepth = 8,
    parameter int MaxOutRead   = 16
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          CmdInValid,
    output logic                          CmdInReady,
    input  logic [DDRCWidth-1:0]          CmdIn,
    input  logic [DDRAWidth-1:0]          AddrIn,
    input  logic                          WDataInValid,
    output logic                          WDataInReady,
    input  logic [DDRDWidth-1:0]          WDataIn,
    output logic                          DRAMCommandValid,
    input  logic                          DRAMCommandReady,
    output logic [DDRCWidth-1:0]          DRAMCommand,
    output logic [DDRAWidth-1:0]          DRAMCommandAddress,
    output logic                          DRAMWriteDataValid,
    input  logic                          DRAMWriteDataReady,
    output logic [DDRDWidth-1:0]          DRAMWriteData,
    output logic                          DRAMWriteDataEnd,
    input  logic                          DRAMReadDataValid,
    output logic [$clog2(MaxOutRead):0]   OutReadCount,
    output logic                          Idle,
    output logic [1:0]                    FsmState
);
    import dram_cmd_issuer_pkg::*;

    localparam int CntW  = log2(MaxOutRead) + 1;
    localparam int BeatW = (WBeatsPerCmd > 1) ? log2(WBeatsPerCmd) : 1;
    localparam int EntW  = DDRCWidth + DDRAWidth;
    localparam logic [DDRCWidth-1:0] CmdRead  = DDRCWidth'(DDR3CMD_Read);
    localparam logic [DDRCWidth-1:0] CmdWrite = DDRCWidth'(DDR3CMD_Write);
    localparam logic [BeatW-1:0]     LastBeat = BeatW'(WBeatsPerCmd - 1);

    state_t                  state;
    state_t                  state_next;
    logic [BeatW-1:0]        beat_cnt;
    logic [BeatW-1:0]        beat_cnt_next;
    logic [CntW-1:0]         out_cnt;
    logic [CntW-1:0]         out_cnt_next;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [log2(CmdFIFODepth):0] fifo_count;
    logic                    pop;
    logic                    read_issue;
    logic [EntW-1:0]         head;
    logic [DDRCWidth-1:0]    head_cmd;
    logic [DDRAWidth-1:0]    head_addr;

    cmd_fifo #(
        .Width (EntW),
        .Depth (CmdFIFODepth)
    ) u_cmd_fifo (
        .Clock     (Clock),
        .Reset     (Reset),
        .PushValid (CmdInValid),
        .PushData  ({CmdIn, AddrIn}),
        .PopEnable (pop),
        .HeadData  (head),
        .Full      (fifo_full),
        .Empty     (fifo_empty),
        .Count     (fifo_count)
    );

    // Command/address/data come straight from the FIFO head and the input
    // beat, so they stay stable for as long as their valid is held.
    assign {head_cmd, head_addr} = head;
    assign CmdInReady         = !fifo_full;
    assign DRAMCommand        = head_cmd;
    assign DRAMCommandAddress = head_addr;
    assign DRAMWriteData      = WDataIn;
    assign OutReadCount       = out_cnt;
    assign FsmState           = state;
    assign Idle               = (fifo_count == '0) && (state == ST_Idle) && (out_cnt == '0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_Idle;
            beat_cnt <= '0;
            out_cnt  <= '0;
        end else begin
            state    <= state_next;
            beat_cnt <= beat_cnt_next;
            out_cnt  <= out_cnt_next;
        end
    end

    always_comb begin
        state_next         = state;
        beat_cnt_next      = beat_cnt;
        DRAMCommandValid   = 1'b0;
        DRAMWriteDataValid = 1'b0;
        DRAMWriteDataEnd   = 1'b0;
        WDataInReady       = 1'b0;
        pop                = 1'b0;
        read_issue         = 1'b0;
        case (state)
            ST_Idle: begin
                if (!fifo_empty) begin
                    if (head_cmd == CmdWrite) begin
                        state_next = ST_WData;
                    end else if (int'(out_cnt) + WBeatsPerCmd <= MaxOutRead) begin
                        state_next = ST_Cmd;
                    end
                end
            end
            ST_WData: begin
                DRAMWriteDataValid = WDataInValid;
                WDataInReady       = DRAMWriteDataReady;
                DRAMWriteDataEnd   = (beat_cnt == LastBeat);
                if (WDataInValid && DRAMWriteDataReady) begin
                    if (beat_cnt == LastBeat) begin
                        beat_cnt_next = '0;
                        state_next    = ST_Cmd;
                    end else begin
                        beat_cnt_next = beat_cnt + BeatW'(1);
                    end
                end
            end
            ST_Cmd: begin
                DRAMCommandValid = 1'b1;
                if (DRAMCommandReady) begin
                    pop        = 1'b1;
                    read_issue = (head_cmd == CmdRead);
                    state_next = ST_Idle;
                end
            end
            default: state_next = ST_Idle;
        endcase
    end

    // Issue and return in the same cycle net out; a stray return at zero
    // leaves the count at zero.
    always_comb begin
        int cnt_i;
        cnt_i = int'(out_cnt) + (read_issue ? WBeatsPerCmd : 0) - (DRAMReadDataValid ? 1 : 0);
        if (cnt_i < 0) cnt_i = 0;
        out_cnt_next = CntW'(cnt_i);
    end

`ifdef SIMULATION
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            assert (!(DRAMReadDataValid && (out_cnt == '0) && !read_issue))
                else $error("read data returned with no outstanding reads");
        end
    end
`endif

endmodule

// File: tb/tb_dram_cmd_issuer.sv
// Directed bench for dram_cmd_issuer: a transaction-level model tracks queued
// commands, data progress and outstanding reads; outputs are checked every cycle.
module tb_dram_cmd_issuer;
    import dram_cmd_issuer_pkg::*;

    localparam int CW    = 3;
    localparam int AW    = 28;
    localparam int DW    = 512;
    localparam int W     = 2;
    localparam int MAXR  = 8;
    localparam int DEPTH = 8;

    logic          Clock;
    logic          Reset;
    logic          CmdInValid;
    logic          CmdInReady;
    logic [CW-1:0] CmdIn;
    logic [AW-1:0] AddrIn;
    logic          WDataInValid;
    logic          WDataInReady;
    logic [DW-1:0] WDataIn;
    logic          DRAMCommandValid;
    logic          DRAMCommandReady;
    logic [CW-1:0] DRAMCommand;
    logic [AW-1:0] DRAMCommandAddress;
    logic          DRAMWriteDataValid;
    logic          DRAMWriteDataReady;
    logic [DW-1:0] DRAMWriteData;
    logic          DRAMWriteDataEnd;
    logic          DRAMReadDataValid;
    logic [3:0]    OutReadCount;
    logic          Idle;
    logic [1:0]    FsmState;

    dram_cmd_issuer #(
        .DDRCWidth    (CW),
        .DDRAWidth    (AW),
        .DDRDWidth    (DW),
        .WBeatsPerCmd (W),
        .CmdFIFODepth (DEPTH),
        .MaxOutRead   (MAXR)
    ) dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .CmdInValid         (CmdInValid),
        .CmdInReady         (CmdInReady),
        .CmdIn              (CmdIn),
        .AddrIn             (AddrIn),
        .WDataInValid       (WDataInValid),
        .WDataInReady       (WDataInReady),
        .WDataIn            (WDataIn),
        .DRAMCommandValid   (DRAMCommandValid),
        .DRAMCommandReady   (DRAMCommandReady),
        .DRAMCommand        (DRAMCommand),
        .DRAMCommandAddress (DRAMCommandAddress),
        .DRAMWriteDataValid (DRAMWriteDataValid),
        .DRAMWriteDataReady (DRAMWriteDataReady),
        .DRAMWriteData      (DRAMWriteData),
        .DRAMWriteDataEnd   (DRAMWriteDataEnd),
        .DRAMReadDataValid  (DRAMReadDataValid),
        .OutReadCount       (OutReadCount),
        .Idle               (Idle),
        .FsmState           (FsmState)
    );

    // ---------------- clock / reset ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    typedef struct packed {
        logic [CW-1:0] cmd;
        logic [AW-1:0] addr;
    } ent_t;

    // Model: queued commands, where the head transaction is in its lifecycle
    // (0 = waiting for a decision cycle, 1 = moving data, 2 = command offered),
    // beats moved for the head write, and outstanding read beats.
    ent_t mq[$];
    int   m_stage = 0;
    int   m_beats = 0;
    int   m_out   = 0;
    bit   check_en = 1'b0;

    int            cyc = 0;
    int            obs_cmds = 0;
    int            obs_beats = 0;
    int            cv_cycles = 0;
    int            wd_taken = 0;
    int            last_end_cyc = 0;
    int            last_cmd_cyc = 0;
    logic [7:0]    obs_end_bits = '0;
    logic [AW-1:0] obs_addr[$];
    bit            prev_stall = 1'b0;
    logic [CW-1:0] prev_cmd;
    logic [AW-1:0] prev_addr;

    always @(negedge Clock) begin : compare
        bit   e_cr, e_cv, e_wv, e_wr, e_we, e_idle, push;
        ent_t hd;
        e_cr   = mq.size() < DEPTH;
        e_cv   = (m_stage == 2);
        e_wv   = (m_stage == 1) && WDataInValid;
        e_wr   = (m_stage == 1) && DRAMWriteDataReady;
        e_we   = (m_stage == 1) && (m_beats == W - 1);
        e_idle = (mq.size() == 0) && (m_stage == 0) && (m_out == 0);
        if (check_en) begin
            check("cmd_in_ready", CmdInReady, e_cr);
            check("dram_cmd_valid", DRAMCommandValid, e_cv);
            check("wdata_valid", DRAMWriteDataValid, e_wv);
            check("wdata_in_ready", WDataInReady, e_wr);
            check("wdata_end", DRAMWriteDataEnd, e_we);
            check("idle", Idle, e_idle);
            check("out_read_count", OutReadCount, m_out);
            if (e_cv) begin
                check("dram_cmd", DRAMCommand, mq[0].cmd);
                check("dram_addr", DRAMCommandAddress, mq[0].addr);
            end
            if (e_wv) check("wdata_pass", 64'(DRAMWriteData == WDataIn), 1);
            if (prev_stall) check("cmd_held", {DRAMCommand, DRAMCommandAddress}, {prev_cmd, prev_addr});
        end
        cyc++;
        if (DRAMCommandValid === 1'b1) cv_cycles++;
        if (DRAMCommandValid === 1'b1 && DRAMCommandReady) begin
            obs_cmds++;
            obs_addr.push_back(DRAMCommandAddress);
            last_cmd_cyc = cyc;
        end
        if (DRAMWriteDataValid === 1'b1 && DRAMWriteDataReady) begin
            obs_beats++;
            obs_end_bits = {obs_end_bits[6:0], DRAMWriteDataEnd};
            if (DRAMWriteDataEnd) last_end_cyc = cyc;
        end
        if (WDataInValid && WDataInReady === 1'b1) wd_taken++;
        prev_stall = (DRAMCommandValid === 1'b1) && !DRAMCommandReady && !Reset;
        prev_cmd   = DRAMCommand;
        prev_addr  = DRAMCommandAddress;

        if (Reset) begin
            mq.delete();
            m_stage = 0;
            m_beats = 0;
            m_out   = 0;
        end else begin
            push = CmdInValid && e_cr;
            hd   = (mq.size() > 0) ? mq[0] : '0;
            case (m_stage)
                0: if (mq.size() > 0) begin
                    if (hd.cmd == DDR3CMD_Write) m_stage = 1;
                    else if (m_out + W <= MAXR) m_stage = 2;
                end
                1: if (WDataInValid && DRAMWriteDataReady) begin
                    m_beats++;
                    if (m_beats == W) begin
                        m_beats = 0;
                        m_stage = 2;
                    end
                end
                default: if (DRAMCommandReady) begin
                    void'(mq.pop_front());
                    if (hd.cmd == DDR3CMD_Read) m_out += W;
                    m_stage = 0;
                end
            endcase
            if (DRAMReadDataValid && m_out > 0) m_out--;
            if (push) mq.push_back('{cmd: CmdIn, addr: AddrIn});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic push_cmd(input logic [CW-1:0] c, input logic [AW-1:0] a);
        bit acc;
        acc = 1'b0;
        CmdInValid = 1'b1;
        CmdIn      = c;
        AddrIn     = a;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge Clock);
            acc = CmdInReady;
            tick();
        end
        CmdInValid = 1'b0;
        if (!acc) check("push_timeout", 0, 1);
    endtask

    task automatic send_beat(input logic [DW-1:0] d);
        bit acc;
        acc = 1'b0;
        WDataInValid = 1'b1;
        WDataIn      = d;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge Clock);
            acc = WDataInReady;
            tick();
        end
        WDataInValid = 1'b0;
        if (!acc) check("beat_timeout", 0, 1);
    endtask

    // Run until the model has nothing queued; optionally return reads and
    // wiggle the controller readies.
    task automatic wait_quiet(input int budget, input bit auto_ret, input bit toggle);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (mq.size() == 0 && m_stage == 0 && (m_out == 0 || !auto_ret)) begin
                done = 1'b1;
                break;
            end
            DRAMReadDataValid = auto_ret && (m_out > 0);
            if (toggle) begin
                DRAMCommandReady   = ~DRAMCommandReady;
                DRAMWriteDataReady = (i % 3) != 0;
                WDataIn            = {64{wd_taken[7:0]}};
            end
            tick();
        end
        DRAMReadDataValid = 1'b0;
        check("quiet_timeout", 64'(done), 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base_cmds, base_beats, base_cv, base_wd;
        Reset = 1'b1; CmdInValid = 1'b0; CmdIn = '0; AddrIn = '0;
        WDataInValid = 1'b0; WDataIn = '0; DRAMCommandReady = 1'b0;
        DRAMWriteDataReady = 1'b0; DRAMReadDataValid = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        check_en = 1'b1;

        // Reset state
        @(negedge Clock);
        check("rst_idle", Idle, 1);
        check("rst_cmd_in_ready", CmdInReady, 1);
        check("rst_cmd_valid", DRAMCommandValid, 0);
        check("rst_wdata_valid", DRAMWriteDataValid, 0);
        check("rst_wdata_end", DRAMWriteDataEnd, 0);
        check("rst_wdata_in_ready", WDataInReady, 0);
        check("rst_out_count", OutReadCount, 0);
        check("rst_state", FsmState, ST_Idle);
        tick();

        // Three reads, then six returned beats
        DRAMCommandReady = 1'b1;
        obs_addr.delete();
        push_cmd(DDR3CMD_Read, 28'h000);
        push_cmd(DDR3CMD_Read, 28'h008);
        push_cmd(DDR3CMD_Read, 28'h010);
        wait_quiet(50, 1'b0, 1'b0);
        @(negedge Clock);
        check("t1_out_count", OutReadCount, 6);
        check("t1_n_cmds", obs_addr.size(), 3);
        for (int i = 0; i < obs_addr.size() && i < 3; i++) check("t1_addr", obs_addr[i], 28'(i * 8));
        tick();
        DRAMReadDataValid = 1'b1;
        repeat (6) tick();
        DRAMReadDataValid = 1'b0;
        @(negedge Clock);
        check("t1_out_zero", OutReadCount, 0);
        check("t1_idle", Idle, 1);
        tick();

        // One write with data arriving late
        obs_addr.delete();
        base_cv    = cv_cycles;
        base_beats = obs_beats;
        DRAMWriteDataReady = 1'b1;
        push_cmd(DDR3CMD_Write, 28'h040);
        repeat (5) tick();
        check("t2_no_cmd_before_data", cv_cycles - base_cv, 0);
        send_beat({64{8'hA5}});
        send_beat({64{8'h5A}});
        wait_quiet(20, 1'b0, 1'b0);
        check("t2_beats", obs_beats - base_beats, 2);
        check("t2_end_flags", obs_end_bits[1:0], 2'b01);
        check("t2_cmd_after_end", last_cmd_cyc - last_end_cyc, 1);
        check("t2_n_cmds", obs_addr.size(), 1);
        if (obs_addr.size() > 0) check("t2_addr", obs_addr[0], 28'h040);

        // Read cap: four reads fill the budget, the fifth waits for returns
        base_cmds = obs_cmds;
        for (int i = 0; i < 6; i++) push_cmd(DDR3CMD_Read, 28'(28'h100 + i * 8));
        repeat (20) tick();
        check("t3_issued_at_cap", obs_cmds - base_cmds, 4);
        @(negedge Clock);
        check("t3_out_at_cap", OutReadCount, 8);
        tick();
        DRAMReadDataValid = 1'b1;
        tick(); tick();
        DRAMReadDataValid = 1'b0;
        repeat (5) tick();
        check("t3_fifth_issued", obs_cmds - base_cmds, 5);
        wait_quiet(100, 1'b1, 1'b0);
        check("t3_all_issued", obs_cmds - base_cmds, 6);

        // Fill the FIFO with the controller stalled, then drain in order
        obs_addr.delete();
        DRAMCommandReady = 1'b0;
        for (int i = 0; i < 8; i++) push_cmd(DDR3CMD_Read, 28'(28'h200 + i * 8));
        CmdInValid = 1'b1;
        CmdIn      = DDR3CMD_Read;
        AddrIn     = 28'h3F8;
        @(negedge Clock);
        check("t4_full_ready", CmdInReady, 0);
        tick();
        CmdInValid = 1'b0;
        DRAMCommandReady = 1'b1;
        fork
            begin
                repeat (9) tick();
                push_cmd(DDR3CMD_Read, 28'h240);
            end
            wait_quiet(300, 1'b1, 1'b0);
        join
        wait_quiet(100, 1'b1, 1'b0);
        check("t4_n_cmds", obs_addr.size(), 9);
        for (int i = 0; i < obs_addr.size() && i < 9; i++) check("t4_order", obs_addr[i], 28'(28'h200 + i * 8));

        // Read/write mix with the command ready toggling
        obs_addr.delete();
        base_cmds  = obs_cmds;
        base_beats = obs_beats;
        DRAMCommandReady = 1'b0;
        WDataInValid = 1'b1;
        push_cmd(DDR3CMD_Read,  28'h300);
        push_cmd(DDR3CMD_Write, 28'h308);
        push_cmd(DDR3CMD_Read,  28'h310);
        push_cmd(DDR3CMD_Write, 28'h318);
        wait_quiet(300, 1'b1, 1'b1);
        WDataInValid = 1'b0;
        DRAMCommandReady = 1'b1;
        check("t5_cmds", obs_cmds - base_cmds, 4);
        check("t5_beats", obs_beats - base_beats, 4);
        for (int i = 0; i < obs_addr.size() && i < 4; i++) check("t5_order", obs_addr[i], 28'(28'h300 + i * 8));

        // Reset while waiting for write data
        DRAMWriteDataReady = 1'b0;
        WDataInValid = 1'b1;
        WDataIn      = {64{8'h3C}};
        push_cmd(DDR3CMD_Write, 28'h400);
        tick();
        @(negedge Clock);
        check("t6_in_wdata", FsmState, ST_WData);
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        DRAMWriteDataReady = 1'b1;
        base_cv    = cv_cycles;
        base_beats = obs_beats;
        base_wd    = wd_taken;
        @(negedge Clock);
        check("t6_wdata_valid", DRAMWriteDataValid, 0);
        check("t6_wdata_in_ready", WDataInReady, 0);
        check("t6_idle", Idle, 1);
        tick();
        repeat (5) tick();
        check("t6_no_cmd", cv_cycles - base_cv, 0);
        check("t6_no_beats", obs_beats - base_beats, 0);
        check("t6_no_consume", wd_taken - base_wd, 0);
        WDataInValid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
